md_unit: RTL and testbench

- Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers; it is the sequential companion to the single-cycle ALU in the execute stage.
- It accepts mult/multu/div/divu/mthi/mtlo from E stage and holds busy for a fixed latency per operation class.
- The hazard unit stalls the pipeline on busy, or on a new start while busy.
- HI/LO are read combinationally for mfhi/mflo.

---
 rtl/md_unit.sv | 142 ++++++++++++++
 tb/tb_md_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Results are committed after a fixed latency per operation class; mthi/mtlo write immediately.
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             cancel,
    input  logic [3:0]       mdOp,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES) + 1;
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6
    } md_op_t;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_next;
    logic [CW-1:0]    count, count_next;
    md_op_t           op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             accept, is_long, commit;
    logic [WIDTH-1:0] res_hi, res_lo;

    assign busy    = (state == RUN);
    assign accept  = start && !cancel && !busy && (mdOp >= 4'd1) && (mdOp <= 4'd6);
    assign is_long = (mdOp >= 4'd1) && (mdOp <= 4'd4);

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        count_next = count;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (accept && is_long) begin
                    state_next = RUN;
                    count_next = (mdOp == OP_DIV || mdOp == OP_DIVU) ? DIV_LOAD : MULT_LOAD;
                end
            end
            RUN: begin
                if (count == '0) begin
                    commit     = 1'b1;
                    state_next = IDLE;
                end else begin
                    count_next = count - CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q <= OP_NONE;
            a_q  <= '0;
            b_q  <= '0;
        end else if (accept && is_long) begin
            op_q <= md_op_t'(mdOp);
            a_q  <= srcA;
            b_q  <= srcB;
        end
    end

    logic [2*WIDTH-1:0] prod_s, prod_u;
    logic [WIDTH-1:0]   dvd, dvs, dvs_safe, quo_u, rem_u;
    logic               a_neg, b_neg;

    // Signed division runs on magnitudes; signs are restored afterwards (quotient toward zero).
    always_comb begin
        prod_s   = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
        prod_u   = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
        a_neg    = (op_q == OP_DIV) && a_q[WIDTH-1];
        b_neg    = (op_q == OP_DIV) && b_q[WIDTH-1];
        dvd      = a_neg ? -a_q : a_q;
        dvs      = b_neg ? -b_q : b_q;
        dvs_safe = (dvs == '0) ? WIDTH'(1) : dvs;
        quo_u    = dvd / dvs_safe;
        rem_u    = dvd % dvs_safe;
        res_hi   = hi;
        res_lo   = lo;
        case (op_q)
            OP_MULT:  {res_hi, res_lo} = prod_s;
            OP_MULTU: {res_hi, res_lo} = prod_u;
            OP_DIV, OP_DIVU: begin
                if (b_q == '0) begin
                    res_lo = '1;
                    res_hi = a_q;
                end else begin
                    res_lo = (a_neg ^ b_neg) ? -quo_u : quo_u;
                    res_hi = a_neg ? -rem_u : rem_u;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (commit) begin
            hi <= res_hi;
            lo <= res_lo;
        end else if (accept && mdOp == OP_MTHI) begin
            hi <= srcA;
        end else if (accept && mdOp == OP_MTLO) begin
            lo <= srcA;
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: scoreboard of expected HI/LO pairs, one task per scenario.
module tb_md_unit;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam int         NMULT    = 5;
    localparam int         NDIV     = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        cancel = 1'b0;
    logic [3:0]  mdOp = 4'd0;
    logic [31:0] srcA = 32'd0;
    logic [31:0] srcB = 32'd0;
    logic        busy;
    logic [31:0] hi, lo;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    logic [31:0] hi_m = 32'd0;
    logic [31:0] lo_m = 32'd0;

    md_unit #(.WIDTH(32), .MULT_CYCLES(NMULT), .DIV_CYCLES(NDIV)) dut (
        .clk(clk), .reset(reset), .start(start), .cancel(cancel), .mdOp(mdOp),
        .srcA(srcA), .srcB(srcB), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model, written with the language's own signed arithmetic.
    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        logic [63:0]        p;
        sa = a;
        sb = b;
        case (op)
            OP_MULT:  begin p = 64'($signed(a)) * 64'($signed(b)); return p; end
            OP_MULTU: begin p = 64'(a) * 64'(b); return p; end
            OP_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                return {32'(sa % sb), 32'(sa / sb)};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    task automatic pop_compare(input string name);
        logic [63:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, got hi=%h lo=%h", name, hi, lo);
        end else begin
            e = exp_q.pop_front();
            if ({hi, lo} !== e) begin
                errors++;
                $display("FAIL %s: got hi=%h lo=%h, expected hi=%h lo=%h", name, hi, lo, e[63:32], e[31:0]);
            end
            hi_m = e[63:32];
            lo_m = e[31:0];
        end
    endtask

    // Issue one long op in the current cycle and follow it to completion.
    task automatic run_long(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [63:0] e, input string name);
        int n;
        n = (op == OP_DIV || op == OP_DIVU) ? NDIV : NMULT;
        exp_q.push_back(e);
        start = 1'b1; cancel = 1'b0; mdOp = op; srcA = a; srcB = b;
        tick();
        start = 1'b0; mdOp = 4'd0;
        for (int k = 1; k <= n; k++) begin
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL %s busy cycle %0d: got busy=%b, expected 1", name, k, busy);
            end
            checks++;
            if ({hi, lo} !== {hi_m, lo_m}) begin
                errors++;
                $display("FAIL %s hold cycle %0d: got hi=%h lo=%h, expected hi=%h lo=%h", name, k, hi, lo, hi_m, lo_m);
            end
            tick();
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s done: got busy=%b, expected 0", name, busy);
        end
        pop_compare(name);
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({busy, hi, lo} !== 65'd0) begin
            errors++;
            $display("FAIL reset: got busy=%b hi=%h lo=%h, expected all zero", busy, hi, lo);
        end
        #4 reset = 1'b0;
        tick();
    endtask

    task automatic test_plan_ops();
        run_long(OP_MULT,  32'hFFFF_FFFD, 32'd5, {32'hFFFF_FFFF, 32'hFFFF_FFF1}, "mult_neg3x5");
        run_long(OP_MULTU, 32'hFFFF_FFFF, 32'd2, {32'h0000_0001, 32'hFFFF_FFFE}, "multu_max_x2");
        run_long(OP_DIV,   32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "div_neg7_by2");
        run_long(OP_DIVU,  32'd7, 32'd0, {32'h0000_0007, 32'hFFFF_FFFF}, "divu_by_zero");
        run_long(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, "div_overflow");
        run_long(OP_DIV,   32'd0, 32'd0, {32'h0000_0000, 32'hFFFF_FFFF}, "div_zero_by_zero");
    endtask

    task automatic test_mthi_mtlo();
        exp_q.push_back({32'h1234_5678, lo_m});
        start = 1'b1; mdOp = OP_MTHI; srcA = 32'h1234_5678; srcB = 32'hDEAD_BEEF;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL mthi busy: got %b, expected 0", busy);
        end
        pop_compare("mthi");
        exp_q.push_back({32'h1234_5678, 32'h9ABC_DEF0});
        mdOp = OP_MTLO; srcA = 32'h9ABC_DEF0;
        tick();
        start = 1'b0; mdOp = 4'd0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL mtlo busy: got %b, expected 0", busy);
        end
        pop_compare("mtlo");
    endtask

    task automatic test_cancel();
        start = 1'b1; cancel = 1'b1; mdOp = OP_MULT; srcA = 32'd3; srcB = 32'd3;
        tick();
        start = 1'b0; cancel = 1'b0; mdOp = 4'd0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({busy, hi, lo} !== {1'b0, hi_m, lo_m}) begin
                errors++;
                $display("FAIL cancel cycle %0d: got busy=%b hi=%h lo=%h, expected busy=0 hi=%h lo=%h",
                         k, busy, hi, lo, hi_m, lo_m);
            end
            tick();
        end
        // Undefined op codes are ignored as well.
        start = 1'b1; mdOp = 4'd9; srcA = 32'h5555_5555;
        tick();
        start = 1'b0; mdOp = 4'd0;
        checks++;
        if ({busy, hi, lo} !== {1'b0, hi_m, lo_m}) begin
            errors++;
            $display("FAIL bad_op: got busy=%b hi=%h lo=%h, expected busy=0 hi=%h lo=%h", busy, hi, lo, hi_m, lo_m);
        end
    endtask

    task automatic test_busy_drop();
        exp_q.push_back({32'd2, 32'd14});
        start = 1'b1; mdOp = OP_DIV; srcA = 32'd100; srcB = 32'd7;
        tick();
        for (int k = 1; k <= NDIV; k++) begin
            if (k <= 3) begin
                start = 1'b1; mdOp = OP_MULT; cancel = (k == 2);
            end else begin
                start = 1'b0; mdOp = 4'd0; cancel = 1'b0;
            end
            srcA = $urandom;
            srcB = $urandom;
            checks++;
            if (busy !== 1'b1 || {hi, lo} !== {hi_m, lo_m}) begin
                errors++;
                $display("FAIL drop cycle %0d: got busy=%b hi=%h lo=%h, expected busy=1 hi=%h lo=%h",
                         k, busy, hi, lo, hi_m, lo_m);
            end
            tick();
        end
        pop_compare("div_latched_ops");
        tick();
        checks++;
        if (busy !== 1'b0 || {hi, lo} !== {hi_m, lo_m}) begin
            errors++;
            $display("FAIL dropped_mult: got busy=%b hi=%h lo=%h, expected busy=0 hi=%h lo=%h", busy, hi, lo, hi_m, lo_m);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        logic [3:0]  op;
        for (int i = 0; i < 10; i++) begin
            op = 4'(1 + $urandom_range(0, 3));
            a  = $urandom;
            b  = (i % 4 == 3) ? 32'd0 : $urandom;
            if (i % 3 == 1) b = 32'($urandom_range(1, 20)) ^ {32{b[31]}};
            run_long(op, a, b, model(op, a, b), "random_op");
        end
    endtask

    task automatic test_async_reset();
        exp_q.push_back(model(OP_DIV, 32'd1000, 32'd3));
        start = 1'b1; mdOp = OP_DIV; srcA = 32'd1000; srcB = 32'd3;
        tick();
        start = 1'b0; mdOp = 4'd0;
        tick(); tick(); tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset busy: got %b, expected 1", busy);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({busy, hi, lo} !== 65'd0) begin
            errors++;
            $display("FAIL async_reset: got busy=%b hi=%h lo=%h, expected all zero", busy, hi, lo);
        end
        void'(exp_q.pop_front());
        hi_m = 32'd0;
        lo_m = 32'd0;
        #1 reset = 1'b0;
        for (int k = 0; k < NDIV + 3; k++) begin
            tick();
            checks++;
            if ({busy, hi, lo} !== 65'd0) begin
                errors++;
                $display("FAIL post_reset cycle %0d: got busy=%b hi=%h lo=%h, expected all zero", k, busy, hi, lo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_plan_ops();
        test_mthi_mtlo();
        test_cancel();
        test_busy_drop();
        test_back_to_back();
        test_async_reset();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
